// File: rtl/store_merge_unit.sv
// store_merge_unit
//
// Executes sb/sh/sw against a word-addressed data memory. Word stores are
// written directly. Byte and halfword stores read the addressed word, merge
// the register data into the selected lane(s) and write the word back.
// Misaligned or reserved-size requests finish at once with Error set and
// never touch memory.
//
// Parameters:
//   READ_LATENCY  cycles from the MemRead cycle until MemReadData is valid (1..7)
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous, active-high reset
//   StartStore    request strobe, sampled only while idle
//   Size          00 byte, 01 halfword, 10 word, 11 reserved
//   Address       byte address of the store
//   RegData       store source register (byte [7:0], half [15:0], word [31:0])
//   Busy          high from the cycle after acceptance through Done
//   Done          one-cycle completion pulse
//   Error         one-cycle pulse with Done for a rejected request
//   MemAddress    word-aligned address of the active request, 0 when idle
//   MemRead       one-cycle read strobe
//   MemWrite      one-cycle write strobe
//   MemWriteData  merged word while MemWrite=1, otherwise 0
//   MemReadData   word returned by data memory
module store_merge_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StartStore,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] RegData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] MemAddress,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} stateT;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  stateT       state, nextState;
  logic [1:0]  sizeQ;
  logic [1:0]  laneQ;
  logic [15:0] dataQ;
  logic [2:0]  waitCnt;
  logic        reject;
  logic [31:0] writeWord;

  // Replace the addressed byte or halfword of the word read from memory.
  function automatic logic [31:0] mergeWord(input logic [31:0] word,
                                            input logic [15:0] data,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    if (size == SIZE_HALF) begin
      if (lane[1]) merged[31:16] = data;
      else         merged[15:0]  = data;
    end else begin
      case (lane)
        2'd0:    merged[7:0]   = data[7:0];
        2'd1:    merged[15:8]  = data[7:0];
        2'd2:    merged[23:16] = data[7:0];
        default: merged[31:24] = data[7:0];
      endcase
    end
    return merged;
  endfunction

  // Alignment / size legality of the request being offered.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    reject = 1'b0;
    case (Size)
      SIZE_BYTE: reject = 1'b0;
      SIZE_HALF: reject = Address[0];
      SIZE_WORD: reject = |Address[1:0];
      default:   reject = 1'b1;
    endcase
  end

  // Next state plus the word to be written on entry to WRITE. writeWord is
  // zero on every other transition so the registered MemWriteData is 0
  // whenever MemWrite is low.
  always_comb begin
    nextState = state;
    writeWord = '0;
    case (state)
      IDLE: begin
        if (StartStore) begin
          if (reject) begin
            nextState = DONE;
          end else if (Size == SIZE_WORD) begin
            nextState = WRITE;
            writeWord = RegData;
          end else begin
            nextState = READ;
          end
        end
      end
      READ:  nextState = WAIT;
      WAIT: begin
        // waitCnt holds READ_LATENCY in the first WAIT cycle, so reaching 1
        // marks the cycle in which memory data is valid.
        if (waitCnt == 3'd1) begin
          nextState = WRITE;
          writeWord = mergeWord(MemReadData, dataQ, sizeQ, laneQ);
        end
      end
      WRITE:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, request latches and registered outputs. Outputs are computed
  // from nextState so they appear in the same cycle as the state they
  // describe without any combinational path from the inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: all control and datapath registers are reset; there is no
    // memory array here, so clearing everything is cheap and makes an
    // abandoned request leave no residue.
    if (Reset) begin
      state        <= IDLE;
      sizeQ        <= '0;
      laneQ        <= '0;
      dataQ        <= '0;
      waitCnt      <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      MemAddress   <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemWriteData <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= nextState;

      if (state == IDLE && StartStore) begin
        sizeQ <= Size;
        laneQ <= Address[1:0];
        dataQ <= RegData[15:0];
      end

      if (state == READ)      waitCnt <= 3'(READ_LATENCY);
      else if (state == WAIT) waitCnt <= waitCnt - 3'd1;

      Busy         <= (nextState != IDLE);
      Done         <= (nextState == DONE);
      // Only a rejected request goes straight from IDLE to DONE.
      Error        <= (state == IDLE) && (nextState == DONE);
      MemRead      <= (nextState == READ);
      MemWrite     <= (nextState == WRITE);
      MemWriteData <= writeWord;

      if (nextState == IDLE)  MemAddress <= '0;
      else if (state == IDLE) MemAddress <= {Address[31:2], 2'b00};
    end
  end

endmodule
